// File: rtl/tile_fetch.sv
// Scrolling tile-map fetch: 15x32 block-RAM map, 3-stage pixel pipeline feeding color_mapper,
// a handshaked write port and a linear clear sweep that also runs after every reset.
module tile_fetch #(
    parameter int          TILE_BITS  = 4,
    parameter int unsigned CLEAR_TILE = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 blank,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic [9:0]           ScrollX,
    input  logic                 Wr_req,
    input  logic [3:0]           Wr_row,
    input  logic [4:0]           Wr_col,
    input  logic [TILE_BITS-1:0] Wr_tile,
    output logic                 Wr_ack,
    input  logic                 Clear_req,
    output logic                 Busy,
    output logic [TILE_BITS-1:0] TileID,
    output logic [4:0]           TileU,
    output logic [4:0]           TileV,
    output logic                 Blank_out,
    output logic [9:0]           DrawX_out,
    output logic [9:0]           DrawY_out
);

    localparam logic [TILE_BITS-1:0] CLR_VAL   = TILE_BITS'(CLEAR_TILE);
    localparam logic [8:0]           LAST_ENTRY = 9'd479;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t state, state_nxt;
    logic [8:0] clr_cnt, clr_nxt;
    logic       clr_we;
    logic       accept;
    logic [9:0] scroll_q;

    logic [TILE_BITS-1:0] map_mem [0:479];
    logic [TILE_BITS-1:0] rd_q;

    // Pixel pipeline: s1 holds the map address, s2 lines up with the RAM read data.
    logic [9:0] world_x;
    logic       oob;
    logic [8:0] s1_addr;
    logic       s1_oob, s1_blank, s2_oob, s2_blank;
    logic [4:0] s1_u, s1_v, s2_u, s2_v;
    logic [9:0] s1_x, s1_y, s2_x, s2_y;

    assign Busy    = (state == CLEAR);
    assign accept  = Wr_req && !blank && !Busy && !Clear_req && !Wr_ack;
    assign world_x = DrawX + scroll_q;
    assign oob     = (DrawY >= 10'd480);

    always_comb begin
        state_nxt = state;
        clr_nxt   = clr_cnt;
        clr_we    = 1'b0;
        case (state)
            IDLE: begin
                if (Clear_req) begin
                    state_nxt = CLEAR;
                    clr_nxt   = '0;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt == LAST_ENTRY) begin
                    state_nxt = IDLE;
                    clr_nxt   = '0;
                end else begin
                    clr_nxt = clr_cnt + 9'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            scroll_q <= '0;
            Wr_ack   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_nxt;
            Wr_ack  <= accept;
            if (DrawY == 10'd480 && DrawX == 10'd0)
                scroll_q <= ScrollX;
        end
    end

    // Map storage has no reset so it maps onto block RAM; sweep and write never coincide.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (clr_we)
                map_mem[clr_cnt] <= CLR_VAL;
            else if (accept && Wr_row < 4'd15)
                map_mem[{Wr_row, Wr_col}] <= Wr_tile;
        end
        rd_q <= map_mem[s1_addr];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_addr   <= '0;
            s1_oob    <= 1'b0;
            s1_blank  <= 1'b0;
            s1_u      <= '0;
            s1_v      <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
            s2_oob    <= 1'b0;
            s2_blank  <= 1'b0;
            s2_u      <= '0;
            s2_v      <= '0;
            s2_x      <= '0;
            s2_y      <= '0;
            TileID    <= '0;
            TileU     <= '0;
            TileV     <= '0;
            Blank_out <= 1'b0;
            DrawX_out <= '0;
            DrawY_out <= '0;
        end else begin
            s1_addr   <= oob ? 9'd0 : {DrawY[8:5], world_x[9:5]};
            s1_oob    <= oob;
            s1_blank  <= blank;
            s1_u      <= world_x[4:0];
            s1_v      <= DrawY[4:0];
            s1_x      <= DrawX;
            s1_y      <= DrawY;
            s2_oob    <= s1_oob;
            s2_blank  <= s1_blank;
            s2_u      <= s1_u;
            s2_v      <= s1_v;
            s2_x      <= s1_x;
            s2_y      <= s1_y;
            TileID    <= s2_oob ? CLR_VAL : rd_q;
            TileU     <= s2_u;
            TileV     <= s2_v;
            Blank_out <= s2_blank;
            DrawX_out <= s2_x;
            DrawY_out <= s2_y;
        end
    end

endmodule
